// File: rtl/somador_subtrator_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per cycle, LSB first.
// Optional unsigned saturation of the result is enabled by defining ADDSUB_SAT_EN.
module somador_subtrator_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             V,
    output logic             Z,
    output logic             SAT
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t r_state, w_state_next;

    logic [WIDTH-1:0] r_a, r_b;
    logic             r_op, r_carry, r_a_msb, r_b_msb;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_c, r_v, r_z, r_sat;

    logic             w_accept, w_last, w_carry_next, w_v_raw, w_sat;
    logic [DIGIT:0]   w_digit_sum;
    logic [DIGIT-1:0] w_digit;
    logic [WIDTH-1:0] w_acc_next, w_s_final;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_CALC;
            end
            ST_CALC: begin
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(N - 1));

    // Sub uses a true ripple borrow: a negative (DIGIT+1)-bit difference sets the top bit.
    always_comb begin
        if (r_op)
            w_digit_sum = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_carry};
        else
            w_digit_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    end

    assign w_carry_next = w_digit_sum[DIGIT];
    assign w_digit      = w_digit_sum[DIGIT-1:0];

    // Only the N-1 digits already produced need storage; the current digit completes the word.
    generate
        if (DIGIT < WIDTH) begin : g_acc
            logic [WIDTH-DIGIT-1:0] r_acc;
            always_ff @(posedge clk) begin
                if (rst || w_accept)
                    r_acc <= '0;
                else if (r_state == ST_CALC)
                    r_acc <= w_acc_next[WIDTH-1:DIGIT];
            end
            assign w_acc_next = {w_digit, r_acc};
        end else begin : g_noacc
            assign w_acc_next = w_digit;
        end
    endgenerate

    assign w_v_raw = r_op ? ((r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb))
                          : ((r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb));

`ifdef ADDSUB_SAT_EN
    assign w_sat     = w_carry_next;
    assign w_s_final = w_sat ? (r_op ? '0 : '1) : w_acc_next;
`else
    assign w_sat     = 1'b0;
    assign w_s_final = w_acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_sat   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= op;
            r_carry <= 1'b0;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == ST_CALC) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_carry_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_s   <= w_s_final;
                r_c   <= w_carry_next;
                r_v   <= w_v_raw;
                r_z   <= (w_s_final == '0);
                r_sat <= w_sat;
            end
        end
    end

    assign S     = r_s;
    assign C_out = r_c;
    assign V     = r_v;
    assign Z     = r_z;
    assign SAT   = r_sat;

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Bench for somador_subtrator_serial: table vectors plus random ops through a scoreboard,
// with hand sequences for backpressure, mid-operation reset and the single-digit (N=1) build.
module tb_somador_subtrator_serial;

    localparam int N0 = 4;
    localparam int N1 = 1;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       z;
        logic       sat;
    } res_t;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, op, out_valid, out_ready;
    logic [7:0] A, B, S;
    logic       C_out, V, Z, SAT;
    logic       b_in_valid, b_in_ready, b_op, b_out_valid, b_out_ready;
    logic [7:0] b_A, b_B, b_S;
    logic       b_C_out, b_V, b_Z, b_SAT;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    somador_subtrator_serial #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .C_out(C_out), .V(V), .Z(Z), .SAT(SAT)
    );

    somador_subtrator_serial #(.WIDTH(8), .DIGIT(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
        .A(b_A), .B(b_B), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .S(b_S), .C_out(b_C_out), .V(b_V), .Z(b_Z), .SAT(b_SAT)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic res_t mk_res(input logic [7:0] s, input logic c, input logic v,
                                    input logic z, input logic sat);
        res_t r;
        r.s = s; r.c = c; r.v = v; r.z = z; r.sat = sat;
        return r;
    endfunction

    function automatic vec_t mk(input logic o, input logic [7:0] a, input logic [7:0] b,
                                input res_t e);
        vec_t t;
        t.op = o; t.a = a; t.b = b; t.exp = e;
        return t;
    endfunction

    // Reference model in full-width arithmetic.
    function automatic res_t model(input logic o, input logic [7:0] a, input logic [7:0] b);
        res_t       r;
        logic [8:0] t;
        if (!o) begin
            t   = {1'b0, a} + {1'b0, b};
            r.s = t[7:0];
            r.c = t[8];
            r.v = (a[7] == b[7]) && (r.s[7] != a[7]);
        end else begin
            r.s = a - b;
            r.c = (a < b);
            r.v = (a[7] != b[7]) && (r.s[7] != a[7]);
        end
        r.sat = 1'b0;
`ifdef ADDSUB_SAT_EN
        if (r.c) begin
            r.s   = o ? 8'h00 : 8'hFF;
            r.sat = 1'b1;
        end
`endif
        r.z = (r.s == 8'h00);
        return r;
    endfunction

    task automatic cmp_result(input string tag, input res_t got);
        res_t ex;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            ex = sb.pop_front();
            chk({tag, " S"}, 32'(got.s), 32'(ex.s));
            chk({tag, " C_out"}, 32'(got.c), 32'(ex.c));
            chk({tag, " V"}, 32'(got.v), 32'(ex.v));
            chk({tag, " Z"}, 32'(got.z), 32'(ex.z));
            chk({tag, " SAT"}, 32'(got.sat), 32'(ex.sat));
        end
    endtask

    // Called and returns at a negedge.
    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b, input res_t e);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        chk("in_ready_before_op", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; A = a; B = b;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); op = ~o;
        k = 0;
        while (!out_valid && k < 40) begin @(negedge clk); k++; end
        chk("latency_edges", 32'(k + 1), 32'(N0 + 1));
        $display("txn op=%0d A=%02h B=%02h -> S=%02h C=%0d V=%0d Z=%0d SAT=%0d",
                 o, a, b, S, C_out, V, Z, SAT);
        cmp_result("dut", {S, C_out, V, Z, SAT});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_release", 32'(out_valid), 32'd0);
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op1(input logic o, input logic [7:0] a, input logic [7:0] b, input res_t e);
        int k;
        b_in_valid = 1'b1; b_op = o; b_A = a; b_B = b;
        sb.push_back(e);
        @(negedge clk);
        b_in_valid = 1'b0; b_A = 8'($urandom); b_B = 8'($urandom);
        k = 0;
        while (!b_out_valid && k < 40) begin @(negedge clk); k++; end
        chk("n1_latency_edges", 32'(k + 1), 32'(N1 + 1));
        $display("txn N1 op=%0d A=%02h B=%02h -> S=%02h C=%0d V=%0d Z=%0d SAT=%0d",
                 o, a, b, b_S, b_C_out, b_V, b_Z, b_SAT);
        cmp_result("dut1", {b_S, b_C_out, b_V, b_Z, b_SAT});
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk("n1_in_ready_after_release", 32'(b_in_ready), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t e;
        int   k;
        logic o;
        logic [7:0] ra, rb;

        vecs[0]  = mk(1'b1, 8'h05, 8'h03, mk_res(8'h02, 0, 0, 0, 0));
        vecs[2]  = mk(1'b0, 8'h7F, 8'h01, mk_res(8'h80, 0, 1, 0, 0));
        vecs[3]  = mk(1'b1, 8'h80, 8'h01, mk_res(8'h7F, 0, 1, 0, 0));
        vecs[5]  = mk(1'b0, 8'h00, 8'h00, mk_res(8'h00, 0, 0, 1, 0));
        vecs[8]  = mk(1'b0, 8'h3C, 8'hA5, mk_res(8'hE1, 0, 0, 0, 0));
        vecs[9]  = mk(1'b1, 8'h55, 8'h55, mk_res(8'h00, 0, 0, 1, 0));
`ifdef ADDSUB_SAT_EN
        vecs[1]  = mk(1'b1, 8'h03, 8'h05, mk_res(8'h00, 1, 0, 1, 1));
        vecs[4]  = mk(1'b0, 8'hFF, 8'h01, mk_res(8'hFF, 1, 0, 0, 1));
        vecs[6]  = mk(1'b1, 8'h00, 8'h01, mk_res(8'h00, 1, 0, 1, 1));
        vecs[7]  = mk(1'b0, 8'h80, 8'h80, mk_res(8'hFF, 1, 1, 0, 1));
        vecs[10] = mk(1'b1, 8'h7F, 8'hFF, mk_res(8'h00, 1, 1, 1, 1));
`else
        vecs[1]  = mk(1'b1, 8'h03, 8'h05, mk_res(8'hFE, 1, 0, 0, 0));
        vecs[4]  = mk(1'b0, 8'hFF, 8'h01, mk_res(8'h00, 1, 0, 1, 0));
        vecs[6]  = mk(1'b1, 8'h00, 8'h01, mk_res(8'hFF, 1, 0, 0, 0));
        vecs[7]  = mk(1'b0, 8'h80, 8'h80, mk_res(8'h00, 1, 1, 1, 0));
        vecs[10] = mk(1'b1, 8'h7F, 8'hFF, mk_res(8'h80, 1, 1, 0, 0));
`endif

        rst = 1'b1;
        in_valid = 1'b0; op = 1'b0; A = '0; B = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_op = 1'b0; b_A = '0; b_B = '0; b_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset S", 32'(S), 32'd0);
        chk("reset flags", 32'({C_out, V, Z, SAT}), 32'd0);

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 8; i++) begin
            o  = 1'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(o, ra, rb, model(o, ra, rb));
        end

        // Backpressure: result held in DONE while new operands are offered and ignored.
        e = model(1'b0, 8'hF0, 8'h20);
        in_valid = 1'b1; op = 1'b0; A = 8'hF0; B = 8'h20;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin @(negedge clk); k++; end
        chk("bp reached DONE", 32'(out_valid), 32'd1);
        $display("txn backpressure op=0 A=f0 B=20 -> S=%02h C=%0d", S, C_out);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 1'($urandom); A = 8'($urandom); B = 8'($urandom);
            @(negedge clk);
            chk("bp out_valid held", 32'(out_valid), 32'd1);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
            chk("bp S held", 32'(S), 32'(e.s));
            chk("bp C_out held", 32'(C_out), 32'(e.c));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp out_valid dropped", 32'(out_valid), 32'd0);
        chk("bp in_ready back", 32'(in_ready), 32'd1);
        chk("bp S after exit", 32'(S), 32'(e.s));

        // Reset during the second CALC cycle aborts the operation.
        in_valid = 1'b1; op = 1'b1; A = 8'h22; B = 8'h11;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset-abort op=1 A=22 B=11 -> S=%02h out_valid=%0d", S, out_valid);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort S", 32'(S), 32'd0);
        chk("abort flags", 32'({C_out, V, Z, SAT}), 32'd0);
        run_op(1'b1, 8'h10, 8'h01, mk_res(8'h0F, 0, 0, 0, 0));
        k = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        chk("no spurious result", 32'(k), 32'd0);

        // Single-digit configuration (N=1).
        chk("n1 in_ready", 32'(b_in_ready), 32'd1);
        run_op1(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].exp);
        run_op1(vecs[4].op, vecs[4].a, vecs[4].b, vecs[4].exp);
        run_op1(vecs[10].op, vecs[10].a, vecs[10].b, vecs[10].exp);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
